// File: rtl/point_mem_arbiter.sv
// Arbiter sharing one synchronous memory between a single-word core port and a point burst port.
// Build with PT_ARB_CORE_PRIO_EN defined to give the core fixed priority over the point port.
module point_mem_arbiter #(
    parameter int BEATS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [31:0]         core_addr,
    input  logic [31:0]         core_wdata,
    output logic [31:0]         core_rdata,
    output logic                core_ack,
    input  logic                pt_req,
    input  logic                pt_we,
    input  logic [31:0]         pt_addr,
    input  logic [32*BEATS-1:0] pt_wdata,
    output logic [32*BEATS-1:0] pt_rdata,
    output logic                pt_ack,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_we,
    input  logic [31:0]         mem_rdata,
    output logic                busy
);

    localparam int W  = 32 * BEATS;
    localparam int RW = 32 * (BEATS - 1);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        C_ISSUE,
        C_DONE,
        B_RUN,
        B_LAST
    } state_t;

    state_t          state, state_d;
    logic            last_grant, last_grant_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            op_we, op_we_d;
    logic [W-1:0]    wbuf, wbuf_d;
    logic [RW-1:0]   rbuf, rbuf_d;
    logic [31:0]     mem_addr_d, mem_wdata_d, core_rdata_d;
    logic [W-1:0]    pt_rdata_d;
    logic            mem_we_d, core_ack_d, pt_ack_d, busy_d;
    logic            c_ok, p_ok, core_first;
    logic            unused_bits;

    // last_grant = 1 means the point port was served last
`ifdef PT_ARB_CORE_PRIO_EN
    assign core_first = 1'b1;
`else
    assign core_first = last_grant;
`endif

    assign unused_bits = ^{core_addr[1:0], pt_addr[1:0], wbuf[31:0], last_grant};

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        cnt_d        = cnt;
        op_we_d      = op_we;
        wbuf_d       = wbuf;
        rbuf_d       = rbuf;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = mem_we;
        core_rdata_d = core_rdata;
        pt_rdata_d   = pt_rdata;
        core_ack_d   = 1'b0;
        pt_ack_d     = 1'b0;
        busy_d       = busy;
        // a requester still showing its ack is finishing the last access
        c_ok         = core_req && !core_ack;
        p_ok         = pt_req && !pt_ack;

        unique case (state)
            IDLE: begin
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                if (c_ok && (!p_ok || core_first)) begin
                    state_d      = C_ISSUE;
                    last_grant_d = 1'b0;
                    op_we_d      = core_we;
                    mem_addr_d   = {core_addr[31:2], 2'b00};
                    mem_wdata_d  = core_wdata;
                    mem_we_d     = core_we;
                    busy_d       = 1'b1;
                end else if (p_ok) begin
                    state_d      = B_RUN;
                    last_grant_d = 1'b1;
                    op_we_d      = pt_we;
                    wbuf_d       = pt_wdata;
                    cnt_d        = '0;
                    mem_addr_d   = {pt_addr[31:2], 2'b00};
                    mem_wdata_d  = pt_wdata[31:0];
                    mem_we_d     = pt_we;
                    busy_d       = 1'b1;
                end
            end
            C_ISSUE: begin
                mem_we_d = 1'b0;
                state_d  = C_DONE;
            end
            C_DONE: begin
                if (!op_we) core_rdata_d = mem_rdata;
                core_ack_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            B_RUN: begin
                // read data lags the address by one beat
                if (!op_we && cnt != '0)
                    rbuf_d[32*(int'(cnt)-1) +: 32] = mem_rdata;
                if (cnt == LAST) begin
                    mem_we_d = 1'b0;
                    state_d  = B_LAST;
                end else begin
                    cnt_d       = cnt + 1'b1;
                    mem_addr_d  = mem_addr + 32'd4;
                    mem_wdata_d = wbuf[32*(int'(cnt)+1) +: 32];
                end
            end
            B_LAST: begin
                if (!op_we) pt_rdata_d = {mem_rdata, rbuf};
                pt_ack_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            op_we      <= 1'b0;
            wbuf       <= '0;
            rbuf       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            core_rdata <= '0;
            pt_rdata   <= '0;
            core_ack   <= 1'b0;
            pt_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            last_grant <= last_grant_d;
            cnt        <= cnt_d;
            op_we      <= op_we_d;
            wbuf       <= wbuf_d;
            rbuf       <= rbuf_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_we     <= mem_we_d;
            core_rdata <= core_rdata_d;
            pt_rdata   <= pt_rdata_d;
            core_ack   <= core_ack_d;
            pt_ack     <= pt_ack_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_point_mem_arbiter.sv
// Directed bench for point_mem_arbiter with a behavioural synchronous memory.
module tb_point_mem_arbiter;

    localparam int BEATS = 8;
    localparam int W = 32 * BEATS;

    logic          clk, rst;
    logic          core_req, core_we, core_ack;
    logic [31:0]   core_addr, core_wdata, core_rdata;
    logic          pt_req, pt_we, pt_ack;
    logic [31:0]   pt_addr;
    logic [W-1:0]  pt_wdata, pt_rdata;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic          mem_we, busy;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_log [1:16];
    int total = 0;
    int passed = 0;

    point_mem_arbiter #(.BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .pt_req(pt_req), .pt_we(pt_we), .pt_addr(pt_addr),
        .pt_wdata(pt_wdata), .pt_rdata(pt_rdata), .pt_ack(pt_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    end

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // runs n cycles, logging addresses, mem_we count and first ack cycles
    task automatic run(input int n, output int ack_c, output int ack_p,
                       output int we_n);
        ack_c = 0;
        ack_p = 0;
        we_n = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k <= 16) addr_log[k] = mem_addr;
            if (mem_we) we_n++;
            if (core_ack && ack_c == 0) begin
                ack_c = k;
                core_req = 1'b0;
            end
            if (pt_ack && ack_p == 0) begin
                ack_p = k;
                pt_req = 1'b0;
            end
        end
    endtask

    initial begin
        int ac, ap, wn, bad;
        logic [W-1:0] rd_exp, wr_dat;
        logic [31:0] rr2;

        for (int i = 0; i < BEATS; i++) begin
            mem[32'h200 + 32'(4 * i)] = 32'(i);
            rd_exp[32*i +: 32] = 32'(i);
            wr_dat[32*i +: 32] = 32'hA0 + 32'(i);
        end
        mem[32'h100] = 32'hDEADBEEF;

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        pt_req = 0; pt_we = 0; pt_addr = 0; pt_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_addr", W'(mem_addr), W'(0));
        check("rst_mem_we", W'(mem_we), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_core_ack", W'(core_ack), W'(0));
        check("rst_pt_ack", W'(pt_ack), W'(0));
        check("rst_core_rdata", W'(core_rdata), W'(0));
        check("rst_pt_rdata", pt_rdata, W'(0));
        rst = 1'b0;

        // core read
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 32'h100;
        run(6, ac, ap, wn);
        check("cr_ack_cycle", W'(ac), W'(3));
        check("cr_addr", W'(addr_log[1]), W'(32'h100));
        check("cr_rdata", W'(core_rdata), W'(32'hDEADBEEF));

        // burst read
        @(negedge clk);
        pt_req = 1; pt_we = 0; pt_addr = 32'h200;
        run(14, ac, ap, wn);
        bad = 0;
        for (int i = 1; i <= BEATS; i++)
            if (addr_log[i] !== 32'h200 + 32'(4 * (i - 1))) bad++;
        check("br_ack_cycle", W'(ap), W'(10));
        check("br_addr_seq", W'(bad), W'(0));
        check("br_we_cnt", W'(wn), W'(0));
        check("br_rdata", pt_rdata, rd_exp);

        // burst write across the top of the address space
        @(negedge clk);
        pt_req = 1; pt_we = 1; pt_addr = 32'hFFFFFFF0; pt_wdata = wr_dat;
        run(14, ac, ap, wn);
        check("bw_we_cnt", W'(wn), W'(8));
        check("bw_addr0", W'(addr_log[1]), W'(32'hFFFFFFF0));
        check("bw_addr_wrap", W'(addr_log[5]), W'(32'h0));
        check("bw_addr_last", W'(addr_log[8]), W'(32'hC));
        check("bw_ack_cycle", W'(ap), W'(10));
        check("bw_mem0", W'(mem[32'h0]), W'(32'hA4));
        check("bw_rdata_hold", pt_rdata, rd_exp);

        // misaligned burst base
        @(negedge clk);
        pt_req = 1; pt_we = 0; pt_addr = 32'h203;
        run(14, ac, ap, wn);
        check("ma_addr0", W'(addr_log[1]), W'(32'h200));
        check("ma_addr7", W'(addr_log[8]), W'(32'h21C));
        check("ma_rdata", pt_rdata, rd_exp);

        // core write then read back
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 32'h500;
        core_wdata = 32'h12345678;
        run(6, ac, ap, wn);
        check("cw_ack_cycle", W'(ac), W'(3));
        check("cw_we_cnt", W'(wn), W'(1));
        check("cw_rdata_hold", W'(core_rdata), W'(32'hDEADBEEF));
        @(negedge clk);
        core_req = 1; core_we = 0;
        run(6, ac, ap, wn);
        check("cw_readback", W'(core_rdata), W'(32'h12345678));

        // reset during beat 3 of a burst write
        @(negedge clk);
        pt_req = 1; pt_we = 1; pt_addr = 32'h400; pt_wdata = wr_dat;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ra_mem_we", W'(mem_we), W'(0));
        check("ra_busy", W'(busy), W'(0));
        check("ra_mem_addr", W'(mem_addr), W'(0));
        pt_req = 0;
        @(negedge clk);
        rst = 1'b0;
        run(12, ac, ap, wn);
        check("ra_no_ack", W'(ap), W'(0));
        check("ra_no_we", W'(wn), W'(0));
        check("ra_no_beat3", W'(mem.exists(32'h40C)), W'(0));

        // simultaneous requests, twice
`ifdef PT_ARB_CORE_PRIO_EN
        rr2 = 32'h104;
`else
        rr2 = 32'h300;
`endif
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 32'h104;
        pt_req = 1; pt_we = 0; pt_addr = 32'h300;
        @(posedge clk);
        #1;
        check("rr1_grant", W'(mem_addr), W'(32'h104));
        core_req = 0; pt_req = 0;
        run(14, ac, ap, wn);
        check("rr1_core_ack", W'(ac > 0), W'(1));
        check("rr1_no_pt_ack", W'(ap), W'(0));
        @(negedge clk);
        core_req = 1; pt_req = 1;
        @(posedge clk);
        #1;
        check("rr2_grant", W'(mem_addr), W'(rr2));
        core_req = 0; pt_req = 0;
        run(14, ac, ap, wn);
        check("rr2_idle", W'(busy), W'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
